tdm_demux4: RTL and testbench
=============================

TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter: W, default 1, width of each data sample and of each output channel.
REQ-002 Port: clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: din  input  W  time-multiplexed sample for the current slot.
REQ-005 Port: din_valid  input  1  din is a sample; when low, din and frame_start are ignored.
REQ-006 Port: frame_start  input  1  qualified by din_valid; marks the slot-0 sample.
REQ-007 Port: d0, d1, d2, d3  output  W each  registered channel outputs of the last complete frame.
REQ-008 Port: slot  output  2  slot index expected for the next accepted sample.
REQ-009 Port: frame_valid  output  1  one-cycle pulse when d0..d3 update.
REQ-010 Port: locked  output  1  high while the state machine is in LOCKED.
REQ-011 Port: sync_err  output  1  one-cycle pulse on a framing violation.
REQ-012 Port: err_cnt  output  8  saturating count of sync_err pulses.

Function
REQ-013 Accepted sample: a rising edge with din_valid=1; no state, counter or shadow register changes on any other edge.
REQ-014 States: HUNT and LOCKED.
REQ-015 HUNT, accepted sample with frame_start=1: store din in shadow slot 0, set slot to 1, go to LOCKED.
REQ-016 HUNT, accepted sample with frame_start=0: discard the sample, no error, stay in HUNT.
REQ-017 LOCKED, slot=1 or slot=2, frame_start=0: store din in shadow[slot] and increment slot.
REQ-018 LOCKED, slot=3, frame_start=0, first effect: on that edge, d0..d2 take shadow 0..2 and d3 takes din.
REQ-019 LOCKED, slot=3, frame_start=0, second effect: on the same edge, frame_valid goes high for exactly one cycle, slot wraps to 0, state stays LOCKED.
REQ-020 Latency: d0..d3 and frame_valid are visible in the cycle after the edge that accepts the slot-3 sample.
REQ-021 LOCKED, slot=0, frame_start=1: store din in shadow slot 0 and set slot to 1; back-to-back frames need no idle cycles.
REQ-022 LOCKED, slot=0, frame_start=0 (missing sync): pulse sync_err, discard din, go to HUNT, slot stays 0.
REQ-023 LOCKED, slot in 1..3, frame_start=1 (early sync): pulse sync_err, abandon the partial frame, no frame_valid.
REQ-024 Early-sync recovery: the same sample is taken as slot 0 (shadow slot 0 := din, slot := 1), state stays LOCKED.
REQ-025 d0..d3 change only on the frame-complete edge; between frames, and after errors, they hold their last values.
REQ-026 err_cnt increments by 1 on each sync_err and saturates at 8'hFF.
REQ-027 din_valid=0 mid-frame: the frame stalls without limit and resumes at the same slot.
REQ-028 All outputs are driven from registers; no combinational path from inputs to outputs.

Reset
REQ-029 While rst_n=0, these outputs are 0: d0..d3, slot, frame_valid, locked, sync_err, err_cnt.
REQ-030 While rst_n=0, the state machine is in HUNT and all shadow registers are 0.
REQ-031 Reset asserted mid-frame: the partial frame is abandoned immediately, with no frame_valid and no sync_err.
REQ-032 Release: the first accepted sample is handled under REQ-015/016 on the first rising edge with rst_n=1.

Verification (W=4)
REQ-033 Clean frame: valid samples A,5,C,3 with frame_start on A -> next cycle d0..d3=A,5,C,3, frame_valid=1 for 1 cycle, locked=1, slot=0.
REQ-034 Stall: gap of 3 cycles with din_valid=0 between samples 5 and C -> same result as REQ-033, and frame_valid rises only after 3 is accepted.
REQ-035 Early sync: frame 1,2 then frame_start on 7, followed by 8,9,F -> sync_err pulse, err_cnt=1, d0..d3=7,8,9,F, with no frame_valid for 1,2.
REQ-036 Missing sync: after a complete frame, a valid sample E without frame_start -> sync_err, locked=0, d0..d3 hold the prior frame, E discarded.
REQ-037 Reset mid-frame: rst_n low after samples A,5 -> all outputs 0 and locked=0; then a clean frame 4,3,2,1 -> d0..d3=4,3,2,1.
REQ-038 Saturation: 260 missing-sync events -> err_cnt=FF, with no wrap to 00.

Source files
------------

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer: hunts for frame_start, then collects slots 0..3
// into shadow registers and publishes a complete frame on d0..d3.
module tdm_demux4 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         frame_start,
  output logic [W-1:0] d0,
  output logic [W-1:0] d1,
  output logic [W-1:0] d2,
  output logic [W-1:0] d3,
  output logic [1:0]   slot,
  output logic         frame_valid,
  output logic         locked,
  output logic         sync_err,
  output logic [7:0]   err_cnt
);

  typedef enum logic {HUNT, LOCKED} state_e;

  state_e       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [W-1:0] sh_q [3];
  logic [W-1:0] sh_d [3];
  logic [W-1:0] dout_q [4];
  logic [W-1:0] dout_d [4];
  logic         fv_q, fv_d;
  logic         se_q, se_d;
  logic [7:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      slot_q  <= '0;
      sh_q    <= '{default: '0};
      dout_q  <= '{default: '0};
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    cnt_d   = cnt_q;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (frame_start) begin
            sh_d[0] = din;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (frame_start) begin
            // early sync restarts the frame with this sample as slot 0
            se_d    = (slot_q != 2'd0);
            sh_d[0] = din;
            slot_d  = 2'd1;
          end else if (slot_q == 2'd0) begin
            se_d    = 1'b1;
            state_d = HUNT;
          end else if (slot_q == 2'd3) begin
            dout_d = '{sh_q[0], sh_q[1], sh_q[2], din};
            fv_d   = 1'b1;
            slot_d = 2'd0;
          end else begin
            if (slot_q == 2'd1) sh_d[1] = din;
            else                sh_d[2] = din;
            slot_d = slot_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    if (se_d && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    d0          = dout_q[0];
    d1          = dout_q[1];
    d2          = dout_q[2];
    d3          = dout_q[3];
    slot        = slot_q;
    frame_valid = fv_q;
    locked      = (state_q == LOCKED);
    sync_err    = se_q;
    err_cnt     = cnt_q;
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4 (W=4): frame-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       frame_start = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic [1:0] slot;
  logic       frame_valid, locked, sync_err;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;

  tdm_demux4 #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .slot(slot), .frame_valid(frame_valid), .locked(locked),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the partial frame is a queue of accepted samples.
  logic [3:0] part[$];
  logic [3:0] m_d [4] = '{default: '0};
  bit         m_locked = 0;
  bit         m_fv = 0;
  bit         m_se = 0;
  int         m_cnt = 0;

  task automatic m_err();
    m_se = 1;
    if (m_cnt < 255) m_cnt++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      part.delete();
      m_d = '{default: '0};
      m_locked = 0; m_fv = 0; m_se = 0; m_cnt = 0;
    end else begin
      m_fv = 0;
      m_se = 0;
      if (din_valid) begin
        if (frame_start) begin
          if (m_locked && part.size() != 0) m_err();
          part.delete();
          part.push_back(din);
          m_locked = 1;
        end else if (m_locked) begin
          if (part.size() == 0) begin
            m_err();
            m_locked = 0;
          end else begin
            part.push_back(din);
            if (part.size() == 4) begin
              for (int i = 0; i < 4; i++) m_d[i] = part[i];
              m_fv = 1;
              part.delete();
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic logic [28:0] dut_vec();
    return {d0, d1, d2, d3, slot, frame_valid, locked, sync_err, err_cnt};
  endfunction

  function automatic logic [28:0] model_vec();
    return {m_d[0], m_d[1], m_d[2], m_d[3], 2'(part.size()),
            m_fv, m_locked, m_se, 8'(m_cnt)};
  endfunction

  always @(negedge clk) check("cycle", 64'(dut_vec()), 64'(model_vec()));

  task automatic accept(input logic [3:0] d, input logic fs);
    din = d; frame_start = fs; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; frame_start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(dut_vec()), 64'd0);
    rst_n = 1'b1;

    // clean frame
    accept(4'hA, 1); accept(4'h5, 0); accept(4'hC, 0); accept(4'h3, 0);
    check("clean_data", 64'({d0, d1, d2, d3}), 64'h A5C3);
    check("clean_flags", 64'({frame_valid, locked, slot}), 64'b1_1_00);
    @(negedge clk);
    check("clean_fv_pulse", 64'(frame_valid), 64'd0);

    // stall between 5 and C
    accept(4'hA, 1); accept(4'h5, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_no_fv", 64'({frame_valid, slot}), 64'b0_10);
    end
    accept(4'hC, 0);
    check("stall_fv_before_last", 64'(frame_valid), 64'd0);
    accept(4'h3, 0);
    check("stall_data", 64'({frame_valid, d0, d1, d2, d3}), 64'h1A5C3);

    // missing sync after a complete frame
    accept(4'hE, 0);
    check("miss_flags", 64'({sync_err, locked, slot, err_cnt}), 64'({1'b1, 1'b0, 2'd0, 8'd1}));
    check("miss_hold", 64'({d0, d1, d2, d3}), 64'hA5C3);
    @(negedge clk);
    check("miss_se_pulse", 64'(sync_err), 64'd0);

    // early sync
    do_reset();
    accept(4'h1, 1); accept(4'h2, 0); accept(4'h7, 1);
    check("early_err", 64'({sync_err, frame_valid, locked, slot, err_cnt}),
          64'({1'b1, 1'b0, 1'b1, 2'd1, 8'd1}));
    accept(4'h8, 0); accept(4'h9, 0); accept(4'hF, 0);
    check("early_data", 64'({frame_valid, d0, d1, d2, d3}), 64'h1789F);

    // reset mid-frame
    accept(4'hA, 1); accept(4'h5, 0);
    rst_n = 1'b0;
    #2 check("midreset_zero", 64'(dut_vec()), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept(4'h4, 1); accept(4'h3, 0); accept(4'h2, 0); accept(4'h1, 0);
    check("midreset_frame", 64'({frame_valid, locked, d0, d1, d2, d3}), 64'h3_4321);

    // error counter saturation
    do_reset();
    for (int k = 0; k < 260; k++) begin
      accept(4'(k), 1); accept(4'h1, 0); accept(4'h2, 0); accept(4'h3, 0);
      accept(4'hE, 0);
      if (k == 254) check("cnt_at_255", 64'(err_cnt), 64'hFF);
    end
    check("cnt_saturated", 64'(err_cnt), 64'hFF);

    // randomized traffic, mostly well-formed, with occasional async resets
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      din       = 4'($urandom);
      din_valid = ($urandom_range(0, 9) < 7);
      if (din_valid)
        frame_start = (part.size() == 0) ^ ($urandom_range(0, 19) == 0);
      else
        frame_start = 1'($urandom);
      @(negedge clk);
    end
    din_valid = 1'b0; frame_start = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
